// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan decoder and its pattern decoder:
//   - active-low hex font (segment order gfedcba, bit0 = a) and the blank code
//   - segment bit positions within the seg_n bus
//   - scan FSM state type
// -----------------------------------------------------------------------------
package seg7_pkg;

    // Active-low font, bit6 = g ... bit0 = a
    localparam logic [6:0] SEG7_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG7_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG7_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG7_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG7_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG7_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG7_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG7_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG7_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG7_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG7_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG7_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG7_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG7_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG7_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG7_HEX_F = 7'b0001110;
    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

    // Segment bit positions within seg_n
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    typedef enum logic [1:0] {
        IDLE,
        DWELL,
        HOLD
    } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational inverse of the hex font: maps an active-low 7-segment pattern
// back to its nibble.
//   pattern_i  [6:0] active-low segments, bit0 = a ... bit6 = g
//   nibble_o   [3:0] decoded value (0 when not a hex pattern)
//   is_hex_o         pattern is one of the 16 font entries
//   is_blank_o       pattern is all segments off
// -----------------------------------------------------------------------------
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       is_hex_o,
    output logic       is_blank_o
);

    always_comb begin
        nibble_o   = 4'h0;
        is_hex_o   = 1'b1;
        is_blank_o = 1'b0;
        case (pattern_i)
            SEG7_HEX_0: nibble_o = 4'h0;
            SEG7_HEX_1: nibble_o = 4'h1;
            SEG7_HEX_2: nibble_o = 4'h2;
            SEG7_HEX_3: nibble_o = 4'h3;
            SEG7_HEX_4: nibble_o = 4'h4;
            SEG7_HEX_5: nibble_o = 4'h5;
            SEG7_HEX_6: nibble_o = 4'h6;
            SEG7_HEX_7: nibble_o = 4'h7;
            SEG7_HEX_8: nibble_o = 4'h8;
            SEG7_HEX_9: nibble_o = 4'h9;
            SEG7_HEX_A: nibble_o = 4'hA;
            SEG7_HEX_B: nibble_o = 4'hB;
            SEG7_HEX_C: nibble_o = 4'hC;
            SEG7_HEX_D: nibble_o = 4'hD;
            SEG7_HEX_E: nibble_o = 4'hE;
            SEG7_HEX_F: nibble_o = 4'hF;
            SEG7_BLANK: begin
                is_hex_o   = 1'b0;
                is_blank_o = 1'b1;
            end
            default:    is_hex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Decodes a multiplexed active-low 7-segment bus (segments + digit enables)
// back into hex nibbles. Each digit's pattern must stay stable for
// STABLE_CYCLES registered samples before it is captured.
//
// Parameters:
//   NUM_DIGITS     number of multiplexed digits (1..8)
//   STABLE_CYCLES  identical registered samples needed for a capture (2..255)
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   seg_n        segment drive, active-low, bit0 = a ... bit6 = g
//                (bit7 = dp when SEG7_DP_EN is defined)
//   an_n         digit enables, active-low, one-hot-low selects a digit
//   value        decoded nibbles, digit i at [4i+3:4i]
//   digit_valid  digit i holds a legal hex pattern from its last capture
//   frame_valid  pulse: every digit captured since the previous pulse
//   pattern_err  pulse: captured pattern is neither hex nor blank
//   err_digit    digit index of the last pattern_err
//   dp           (SEG7_DP_EN only) captured decimal point, 1 = lit
//
// Build option: define SEG7_DP_EN to widen seg_n with the decimal point and
// add the dp output.
// -----------------------------------------------------------------------------
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef SEG7_DP_EN
    input  logic [7:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   dp,
`else
    input  logic [6:0]              seg_n,
`endif
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    pattern_err,
    output logic [2:0]              err_digit
);

`ifdef SEG7_DP_EN
    localparam int unsigned SW = 8;
`else
    localparam int unsigned SW = 7;
`endif
    localparam int unsigned BW      = NUM_DIGITS + SW;
    localparam logic [7:0]  CNT_MAX = 8'(STABLE_CYCLES);

    // Input stage
    logic [BW-1:0] sample_q, prev_q;

    // FSM
    seg7_state_e   state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          capture;

    // Captured results
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic                    frame_q, frame_d;
    logic                    perr_q, perr_d;
    logic [2:0]              err_q, err_d;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
`endif

    // Fields of the current sample
    logic [NUM_DIGITS-1:0] sel_an;
    logic [6:0]            sel_seg;
    logic                  same;
    logic                  legal;
    logic [2:0]            sel_idx;
    logic [3:0]            zero_cnt;
    logic [NUM_DIGITS-1:0] new_mask;

    logic [3:0] dec_nibble;
    logic       dec_hex;
    logic       dec_blank;

    assign sel_an  = sample_q[BW-1:SW];
    assign sel_seg = sample_q[SEG_G:SEG_A];
    assign same    = (sample_q == prev_q);

    // One-hot-low select -> digit index; legal only with exactly one low bit
    always_comb begin
        zero_cnt = '0;
        sel_idx  = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!sel_an[i]) begin
                zero_cnt = zero_cnt + 4'd1;
                sel_idx  = 3'(i);
            end
        end
        legal = (zero_cnt == 4'd1);
    end

    seg7_pattern_decode u_decode (
        .pattern_i  (sel_seg),
        .nibble_o   (dec_nibble),
        .is_hex_o   (dec_hex),
        .is_blank_o (dec_blank)
    );

    // Input sample registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '1;
            prev_q   <= '1;
        end else begin
            sample_q <= {an_n, seg_n};
            prev_q   <= sample_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state. The first sample of a new select counts as 1, so the
    // capture fires on the edge where the count would reach STABLE_CYCLES.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (legal) begin
                    state_d = DWELL;
                    cnt_d   = 8'd1;
                end
            end
            DWELL: begin
                if (same) begin
                    if (cnt_q + 8'd1 >= CNT_MAX) begin
                        capture = 1'b1;
                        state_d = HOLD;
                        cnt_d   = CNT_MAX;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (legal) begin
                    state_d = DWELL;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (!same) begin
                    if (legal) begin
                        state_d = DWELL;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture datapath
    assign new_mask = mask_q | ~sel_an;

    always_comb begin
        value_d = value_q;
        valid_d = valid_q;
        mask_d  = mask_q;
        frame_d = 1'b0;
        perr_d  = 1'b0;
        err_d   = err_q;
`ifdef SEG7_DP_EN
        dp_d    = dp_q;
`endif
        if (capture) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (!sel_an[i]) begin
                    if (dec_hex) begin
                        value_d[4*i +: 4] = dec_nibble;
                        valid_d[i]        = 1'b1;
                    end else begin
                        valid_d[i] = 1'b0;
                    end
`ifdef SEG7_DP_EN
                    dp_d[i] = ~sample_q[SEG_DP];
`endif
                end
            end
            if (!dec_hex && !dec_blank) begin
                perr_d = 1'b1;
                err_d  = sel_idx;
            end
            if (&new_mask) begin
                frame_d = 1'b1;
                mask_d  = '0;
            end else begin
                mask_d = new_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            valid_q <= '0;
            mask_q  <= '0;
            frame_q <= 1'b0;
            perr_q  <= 1'b0;
            err_q   <= '0;
`ifdef SEG7_DP_EN
            dp_q    <= '0;
`endif
        end else begin
            value_q <= value_d;
            valid_q <= valid_d;
            mask_q  <= mask_d;
            frame_q <= frame_d;
            perr_q  <= perr_d;
            err_q   <= err_d;
`ifdef SEG7_DP_EN
            dp_q    <= dp_d;
`endif
        end
    end

    assign value       = value_q;
    assign digit_valid = valid_q;
    assign frame_valid = frame_q;
    assign pattern_err = perr_q;
    assign err_digit   = err_q;
`ifdef SEG7_DP_EN
    assign dp          = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Self-checking bench for seg7_scan_decoder. A reference model keeps the
// history of bus values seen at each clock edge and applies the capture rule
// directly: a digit is captured at edge e when the registered samples of
// edges e-S..e-1 are identical and legal and that run started at edge e-S.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int S  = 4;
`ifdef SEG7_DP_EN
    localparam int SW = 8;
`else
    localparam int SW = 7;
`endif
    localparam int BW = ND + SW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [SW-1:0]   seg_n;
    logic [ND-1:0]   an_n;
    logic [4*ND-1:0] value;
    logic [ND-1:0]   digit_valid;
    logic            frame_valid;
    logic            pattern_err;
    logic [2:0]      err_digit;
`ifdef SEG7_DP_EN
    logic [ND-1:0]   dp;
`endif

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (S)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
`ifdef SEG7_DP_EN
        .dp          (dp),
`endif
        .an_n        (an_n),
        .value       (value),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .pattern_err (pattern_err),
        .err_digit   (err_digit)
    );

    // Hex font (gfedcba, active-low), indexed by nibble
    logic [6:0] font [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_checks = 0;
    int n_errors = 0;
    int frame_cnt = 0;
    int perr_cnt  = 0;

    // Model state
    logic [BW-1:0]   hist [0:S+1];
    logic [4*ND-1:0] m_value;
    logic [ND-1:0]   m_valid;
    logic [ND-1:0]   m_mask;
    logic            m_frame;
    logic            m_perr;
    logic [2:0]      m_err;
    logic [ND-1:0]   m_dp;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int count_low(input logic [ND-1:0] a);
        int c = 0;
        for (int i = 0; i < ND; i++) if (!a[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < S + 2; i++) hist[i] = '1;
        m_value = '0; m_valid = '0; m_mask = '0;
        m_frame = 1'b0; m_perr = 1'b0; m_err = '0; m_dp = '0;
    endtask

    task automatic model_edge();
        logic [BW-1:0]   b;
        logic [ND-1:0]   a;
        logic [6:0]      pat;
        logic            run;
        int              d;
        int              n;
        for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {an_n, seg_n};
        m_frame = 1'b0;
        m_perr  = 1'b0;
        b   = hist[1];
        a   = b[BW-1:SW];
        pat = b[6:0];
        run = (count_low(a) == 1) && (hist[S+1] != hist[S]);
        for (int j = 2; j <= S; j++) if (hist[j] != b) run = 1'b0;
        if (run) begin
            d = 0;
            for (int i = 0; i < ND; i++) if (!a[i]) d = i;
            n = -1;
            for (int k = 0; k < 16; k++) if (font[k] == pat) n = k;
            if (n >= 0) begin
                m_value[4*d +: 4] = 4'(n);
                m_valid[d] = 1'b1;
            end else begin
                m_valid[d] = 1'b0;
                if (pat != 7'h7F) begin
                    m_perr = 1'b1;
                    m_err  = 3'(d);
                end
            end
`ifdef SEG7_DP_EN
            m_dp[d] = ~b[7];
`endif
            m_mask[d] = 1'b1;
            if (&m_mask) begin
                m_frame = 1'b1;
                m_mask  = '0;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("value", 32'(value), 32'(m_value));
        check_eq("digit_valid", 32'(digit_valid), 32'(m_valid));
        check_eq("frame_valid", 32'(frame_valid), 32'(m_frame));
        check_eq("pattern_err", 32'(pattern_err), 32'(m_perr));
        check_eq("err_digit", 32'(err_digit), 32'(m_err));
`ifdef SEG7_DP_EN
        check_eq("dp", 32'(dp), 32'(m_dp));
`endif
        if (frame_valid) frame_cnt++;
        if (pattern_err) perr_cnt++;
    endtask

    // Called at a negedge: drive the bus, run one clock, check, return at negedge
    task automatic step(input logic [ND-1:0] an, input logic [7:0] seg8);
        an_n  = an;
        seg_n = seg8[SW-1:0];
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic hold(input logic [ND-1:0] an, input logic [7:0] seg8, input int len);
        for (int i = 0; i < len; i++) step(an, seg8);
    endtask

    function automatic logic [ND-1:0] sel(input int d);
        logic [ND-1:0] one = 1;
        return ~(one << d);
    endfunction

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_value"}, 32'(value), 32'h0);
        check_eq({tag, "_valid"}, 32'(digit_valid), 32'h0);
        check_eq({tag, "_frame"}, 32'(frame_valid), 32'h0);
        check_eq({tag, "_perr"}, 32'(pattern_err), 32'h0);
        check_eq({tag, "_errd"}, 32'(err_digit), 32'h0);
`ifdef SEG7_DP_EN
        check_eq({tag, "_dp"}, 32'(dp), 32'h0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ND-1:0] an;
        logic [7:0]    seg8;
        int            r;
        int            d;
        logic [15:0]   snap;

        rst_n = 1'b0;
        an_n  = '1;
        seg_n = '1;
        model_reset();
        #1;
        check_reset_values("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle bus after reset: nothing captured
        hold('1, 8'hFF, 100);
        check_eq("idle_frames", 32'(frame_cnt), 32'd0);

        // Scan 1,2,3,4 on digits 0..3
        frame_cnt = 0;
        hold(sel(0), {1'b1, font[1]}, 8);
        hold(sel(1), {1'b1, font[2]}, 8);
        hold(sel(2), {1'b1, font[3]}, 8);
        hold(sel(3), {1'b1, font[4]}, 8);
        check_eq("scan_value", 32'(value), 32'h4321);
        check_eq("scan_valid", 32'(digit_valid), 32'hF);
        check_eq("scan_frames", 32'(frame_cnt), 32'd1);

        // Digit 2 too short to capture
        frame_cnt = 0;
        hold(sel(2), {1'b1, 7'b0001000}, 3);
        hold('1, 8'hFF, 6);
        check_eq("short_value", 32'(value), 32'h4321);
        check_eq("short_frames", 32'(frame_cnt), 32'd0);

        // Illegal pattern on digit 1
        perr_cnt = 0;
        hold(sel(1), {1'b1, 7'b1111110}, 8);
        check_eq("err_pulses", 32'(perr_cnt), 32'd1);
        check_eq("err_digit1", 32'(err_digit), 32'd1);
        check_eq("err_valid1", 32'(digit_valid[1]), 32'd0);
        check_eq("err_nibble1", 32'(value[7:4]), 32'h2);

        // Blank on digit 0
        perr_cnt = 0;
        hold(sel(0), 8'hFF, 8);
        check_eq("blank_valid0", 32'(digit_valid[0]), 32'd0);
        check_eq("blank_perr", 32'(perr_cnt), 32'd0);

        // Randomized holds
        for (int h = 0; h < 300; h++) begin
            d  = $urandom_range(0, ND - 1);
            an = sel(d);
            r  = $urandom_range(0, 99);
            seg8[7] = 1'($urandom_range(0, 1));
            if (r < 55)      seg8[6:0] = font[$urandom_range(0, 15)];
            else if (r < 70) seg8[6:0] = 7'h7F;
            else if (r < 85) seg8[6:0] = 7'($urandom_range(0, 127));
            else begin
                seg8[6:0] = font[$urandom_range(0, 15)];
                if ($urandom_range(0, 1) == 1) an = '1;
                else an = sel(d) & sel((d + 1) % ND);
            end
            hold(an, seg8, $urandom_range(1, 2 * S + 2));
        end

        // Reset in the middle of a scan acts immediately
        hold(sel(3), {1'b0, font[8]}, 8);
        snap = 16'(m_value);
        check_eq("pre_reset_nibble3", 32'(value[15:12]), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        check_reset_values("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        hold('1, 8'hFF, 6);
        check_eq("post_reset_frames", 32'(frame_valid), 32'd0);

        for (int h = 0; h < 100; h++) begin
            d    = $urandom_range(0, ND - 1);
            seg8 = {1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                : font[$urandom_range(0, 15)]};
            hold(sel(d), seg8, $urandom_range(1, 2 * S + 2));
        end
        if (snap == 16'hFFFF) check_eq("snap_sentinel", 32'(snap), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
